// File: rtl/traffic_queue_model_pkg.sv
// Shared encodings for the road-side traffic queue model.
package traffic_queue_model_pkg;

  // One-hot light encodings driven by the controller
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  // Per-road queue state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // queue empty
    ST_WAIT = 2'd1,  // cars queued, light not green
    ST_FLOW = 2'd2   // cars queued, light green, cars departing
  } road_st_e;

  // Default counter width and its saturation value
  localparam int WW_DEF    = 8;
  localparam int W_SAT_DEF = (1 << WW_DEF) - 1;

  // True when exactly one of the three lamp bits is lit
  function automatic logic is_onehot3(input logic [2:0] x);
    return (x == LT_GREEN) || (x == LT_YELLOW) || (x == LT_RED);
  endfunction

endpackage

// File: rtl/traffic_queue_model_if.sv
// Light/arrival inputs and queue/status outputs between the stimulus side
// (master) and the queue model (slave).
interface traffic_queue_model_if
  import traffic_queue_model_pkg::*;
#(
  parameter int QW = 4,
  parameter int WW = WW_DEF
);
  logic          arriveA, arriveB;
  logic [2:0]    lightA, lightB;
  logic          carA, carB;
  logic [QW-1:0] qA, qB;
  logic [WW-1:0] servedA, servedB;
  logic [WW-1:0] max_waitA, max_waitB;
  logic          dropA, dropB;
  logic          light_err;

  modport master (
    output arriveA, arriveB, lightA, lightB,
    input  carA, carB, qA, qB, servedA, servedB,
    input  max_waitA, max_waitB, dropA, dropB, light_err
  );

  modport slave (
    input  arriveA, arriveB, lightA, lightB,
    output carA, carB, qA, qB, servedA, servedB,
    output max_waitA, max_waitB, dropA, dropB, light_err
  );
endinterface

// File: rtl/traffic_queue_model_road_queue.sv
// One road: vehicle queue, departure pacing on green, wait-episode tracking,
// served count and sticky drop flag.
module road_queue
  import traffic_queue_model_pkg::*;
#(
  parameter int QW         = 4,
  parameter int MAXQ       = 15,
  parameter int DEPART_CYC = 2,
  parameter int WW         = WW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arrive,
  input  logic [2:0]    light,
  output logic          car,
  output logic [QW-1:0] q,
  output logic [WW-1:0] served,
  output logic [WW-1:0] max_wait,
  output logic          drop
);

  localparam int             DCW      = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [DCW-1:0] DEP_LAST = DCW'(DEPART_CYC - 1);
  localparam logic [QW-1:0]  QMAX     = QW'(MAXQ);
  localparam logic [WW-1:0]  SAT      = {WW{1'b1}};

  road_st_e      st_q, st_d;
  logic [QW-1:0] q_q, q_d;
  logic [DCW-1:0] dep_q, dep_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [WW-1:0] served_q, served_d;
  logic [WW-1:0] maxw_q, maxw_d;
  logic          drop_q, drop_d;
  logic          green, flow_now, depart;

  // Departure pacing: any cycle with cars queued and a green light counts,
  // including the WAIT cycle that first sees green.
  always_comb begin
    green    = (light == LT_GREEN);
    flow_now = (st_q != ST_IDLE) && green;
    depart   = flow_now && (dep_q == DEP_LAST);
    dep_d    = '0;
    if (flow_now && !depart) dep_d = dep_q + 1'b1;
  end

  // Queue occupancy, drop flag and served count; a departure frees the slot
  // that a simultaneous arrival takes, so a full queue accepts it.
  always_comb begin
    q_d      = q_q;
    drop_d   = drop_q;
    served_d = served_q;
    if (arrive && !depart) begin
      if (q_q < QMAX) q_d = q_q + 1'b1;
      else            drop_d = 1'b1;
    end else if (!arrive && depart) begin
      q_d = q_q - 1'b1;
    end
    if (depart && (served_q != SAT)) served_d = served_q + 1'b1;
  end

  // Road FSM with wait-episode measurement
  always_comb begin
    st_d   = st_q;
    wait_d = wait_q;
    maxw_d = maxw_q;
    case (st_q)
      ST_IDLE: if (arrive) st_d = green ? ST_FLOW : ST_WAIT;
      ST_WAIT: begin
        if (green) begin
          st_d   = (q_d == '0) ? ST_IDLE : ST_FLOW;
          wait_d = '0;
          if (wait_q > maxw_q) maxw_d = wait_q;
        end else if (wait_q != SAT) begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FLOW: begin
        if (!green)          st_d = ST_WAIT;
        else if (q_d == '0)  st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      q_q      <= '0;
      dep_q    <= '0;
      wait_q   <= '0;
      served_q <= '0;
      maxw_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      q_q      <= q_d;
      dep_q    <= dep_d;
      wait_q   <= wait_d;
      served_q <= served_d;
      maxw_q   <= maxw_d;
      drop_q   <= drop_d;
    end
  end

  assign car      = (q_q != '0);
  assign q        = q_q;
  assign served   = served_q;
  assign max_wait = maxw_q;
  assign drop     = drop_q;

endmodule

// File: rtl/traffic_queue_model.sv
// Road-side partner of the two-road light controller: two road queues plus
// a sticky checker for illegal light combinations.
module traffic_queue_model
  import traffic_queue_model_pkg::*;
#(
  parameter int QW         = 4,
  parameter int MAXQ       = 15,
  parameter int DEPART_CYC = 2,
  parameter int WW         = WW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_queue_model_if.slave  bus
);

  logic light_bad, light_err_d, light_err_q;

  road_queue #(.QW(QW), .MAXQ(MAXQ), .DEPART_CYC(DEPART_CYC), .WW(WW)) u_road_a (
    .clk      (clk),
    .rst      (rst),
    .arrive   (bus.arriveA),
    .light    (bus.lightA),
    .car      (bus.carA),
    .q        (bus.qA),
    .served   (bus.servedA),
    .max_wait (bus.max_waitA),
    .drop     (bus.dropA)
  );

  road_queue #(.QW(QW), .MAXQ(MAXQ), .DEPART_CYC(DEPART_CYC), .WW(WW)) u_road_b (
    .clk      (clk),
    .rst      (rst),
    .arrive   (bus.arriveB),
    .light    (bus.lightB),
    .car      (bus.carB),
    .q        (bus.qB),
    .served   (bus.servedB),
    .max_wait (bus.max_waitB),
    .drop     (bus.dropB)
  );

  // Illegal when a light is not one-hot or neither road is held at red
  always_comb begin
    light_bad   = !is_onehot3(bus.lightA) || !is_onehot3(bus.lightB) ||
                  ((bus.lightA != LT_RED) && (bus.lightB != LT_RED));
    light_err_d = light_err_q | light_bad;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) light_err_q <= 1'b0;
    else     light_err_q <= light_err_d;
  end

  assign bus.light_err = light_err_q;

endmodule

// File: doc/traffic_queue_model.md
Name: traffic_queue_model

Overview:
- Road-side counterpart of the two-road traffic light controller.
- Consumes the controller's lightA/lightB outputs and per-road car-arrival pulses. Models a vehicle queue on each road and drives the carA/carB sensor lines back to the controller.
- Also tracks served/dropped cars and worst-case wait, and flags illegal light combinations.
- Used as the closed-loop stimulus and checker partner in lab system benches and on-board demos.

Parameters:
QW, 4, queue-count width per road
MAXQ, 15, queue capacity (must be ≤ 2^QW-1)
DEPART_CYC, 2, cycles of continuous green per departing car (≥1)
WW, 8, width of wait-time and served counters (saturating)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
arriveA  input  1  one car arrives on road A this cycle
arriveB  input  1  one car arrives on road B this cycle
lightA  input  3  road A light, one-hot: 001 green, 010 yellow, 100 red
lightB  input  3  road B light, same encoding
carA  output  1  road A queue non-empty (qA != 0)
carB  output  1  road B queue non-empty
qA  output  QW  cars waiting on A
qB  output  QW  cars waiting on B
servedA  output  WW  cars departed from A, saturating
servedB  output  WW  cars departed from B, saturating
max_waitA  output  WW  longest single WAIT episode on A, in cycles
max_waitB  output  WW  same for B
dropA  output  1  sticky: an arrival on A was lost because the queue was full
dropB  output  1  sticky, road B
light_err  output  1  sticky: illegal light combination seen

Behaviour:
- Reset (synchronous): all outputs 0; both road FSMs go to IDLE; departure and wait counters cleared. Reset overrides all other activity mid-operation.
- All counters are registered. carX is combinational from the registered qX, so it rises on the cycle after the first accepted arrival.
- Per-road FSM, identical for A and B; "green" means lightX == 001:
  - IDLE (qX == 0):
    - arrival and not green → WAIT.
    - arrival and green → FLOW.
  - WAIT (qX > 0, not green):
    - wait counter increments each cycle, saturating at 2^WW-1.
    - on green → FLOW. On leaving WAIT, max_waitX = max(max_waitX, wait counter) and the wait counter clears.
  - FLOW (qX > 0, green):
    - departure counter starts at 0 on entry and increments each cycle.
    - when it equals DEPART_CYC-1: one car departs, qX decrements, servedX increments (saturating), and the counter returns to 0.
    - light goes non-green → WAIT with the departure counter cleared. Yellow is treated like red: no departures.
    - qX reaches 0 → IDLE.
- Arrivals, in any state:
  - qX < MAXQ: increment.
  - qX == MAXQ: the car is dropped, dropX is set, and qX is unchanged.
- Arrival and departure in the same cycle: qX unchanged, servedX increments, FSM stays in FLOW. A full queue accepts the arrival in this case because a slot frees; dropX is not set.
- First departure happens DEPART_CYC cycles after the first green cycle observed in FLOW.
- light_err is set on the next clock if either:
  - either light is not one-hot, or
  - neither light is red (e.g. A green with B green or yellow).
- light_err holds until rst. Queue modelling continues while light_err is set.

Decomposition:
- Shared package: light encodings (GREEN/YELLOW/RED), FSM state encodings (IDLE/WAIT/FLOW), and the WW saturation maximum constant.
- One sub-module, road_queue: a single road's FSM, queue, departure, wait, served and drop logic. It is instantiated twice.
- The top level holds only the light_err checker and wiring.

Test Plan:
- Reset → after rst high for 1 cycle: qA=qB=0, carA=carB=0, servedA/B=0, light_err=0, dropA/B=0.
- lightA=100, 3 arrive pulses on A → qA=3; carA=1 from the cycle after the first pulse. Then lightA=001 for 6 cycles → qA steps 2,1,0 at green cycles 2,4,6; servedA=3; carA=0; max_waitA = number of red cycles waited.
- lightB=100, 17 consecutive arriveB → qB=15, dropB=1, and dropB stays 1 after a later green drains the queue to 0.
- qA=15, lightA green, arriveA asserted on the departure cycle → qA stays 15, servedA+1, dropA=0.
- FLOW on A with the departure counter at 1 (DEPART_CYC=2), lightA switches to 010 → no departure; FSM goes to WAIT; on the next green the first departure comes 2 cycles later.
- lightA=001 and lightB=001 for 1 cycle, then legal lights → light_err=1 from the next cycle and held until rst; lightA=011 also sets light_err.
